// File: rtl/picomips_program_counter_pkg.sv
// Shared definitions for the picoMIPS program counter: default address width
// and the next-address selection rule.
`ifndef PROGRAM_CODE_SIZE
`define PROGRAM_CODE_SIZE 8
`endif

package picomips_program_counter_pkg;

  localparam int PC_W_DEFAULT = `PROGRAM_CODE_SIZE;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_STEP = 2'd1,
    PC_WRAP = 2'd2
  } pc_sel_e;

  // At the top address an increment either wraps to zero or saturates.
  function automatic pc_sel_e pc_select(input logic inc, input logic at_max, input logic wrap);
    pc_sel_e sel;
    sel = PC_HOLD;
    if (inc) begin
      if (!at_max) sel = PC_STEP;
      else if (wrap) sel = PC_WRAP;
      else sel = PC_HOLD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/picomips_program_counter.sv
// picoMIPS program counter: registered instruction address that steps by one
// on request and returns to RESET_ADDR asynchronously on reset.
module picomips_program_counter
  import picomips_program_counter_pkg::*;
#(
  parameter int                            program_code_size = PC_W_DEFAULT,
  parameter logic [program_code_size-1:0]  RESET_ADDR        = '0,
  parameter bit                            WRAP              = 1'b1
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         pc_inc,
  output logic [program_code_size-1:0] pc_out
);

  localparam logic [program_code_size-1:0] PC_MAX = '1;

  logic [program_code_size-1:0] pc_q;
  logic [program_code_size-1:0] pc_d;
  pc_sel_e                      pc_sel;

  always_comb begin
    pc_sel = pc_select(pc_inc, (pc_q == PC_MAX), WRAP);
  end

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_STEP: pc_d = pc_q + program_code_size'(1);
      PC_WRAP: pc_d = '0;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) pc_q <= RESET_ADDR;
    else          pc_q <= pc_d;
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_picomips_program_counter.sv
// Bench for picomips_program_counter: three instances (wrapping, saturating,
// non-zero reset address) checked against an arithmetic model every cycle.
module tb_picomips_program_counter;

  logic       clk     = 1'b0;
  logic       n_reset = 1'b1;
  logic       pc_inc  = 1'b0;
  logic [7:0] pc_a, pc_b, pc_c;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  check_en    = 1'b0;
  int  m_a = 0, m_b = 0, m_c = 16;

  picomips_program_counter #(.program_code_size(8), .RESET_ADDR(8'h00), .WRAP(1'b1)) u_wrap (
    .clk(clk), .n_reset(n_reset), .pc_inc(pc_inc), .pc_out(pc_a));

  picomips_program_counter #(.program_code_size(8), .RESET_ADDR(8'h00), .WRAP(1'b0)) u_sat (
    .clk(clk), .n_reset(n_reset), .pc_inc(pc_inc), .pc_out(pc_b));

  picomips_program_counter #(.program_code_size(8), .RESET_ADDR(8'h10), .WRAP(1'b1)) u_ra16 (
    .clk(clk), .n_reset(n_reset), .pc_inc(pc_inc), .pc_out(pc_c));

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: plain modular arithmetic on integers
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_a = 0; m_b = 0; m_c = 16;
    end else if (pc_inc) begin
      m_a = (m_a + 1) % 256;
      m_b = (m_b == 255) ? 255 : m_b + 1;
      m_c = (m_c + 1) % 256;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input int exp);
    logic [7:0] e;
    e = exp[7:0];
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d (%b) expected %0d at %0t", name, act, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every instance on each falling edge
  always @(negedge clk) begin
    if (check_en) begin
      check("wrap_model", pc_a, m_a);
      check("sat_model",  pc_b, m_b);
      check("ra16_model", pc_c, m_c);
    end
  end

  // Drivers
  task automatic pulse_reset();
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    check("rst_async_a", pc_a, 0);
    check("rst_async_b", pc_b, 0);
    check("rst_async_c", pc_c, 16);
    n_reset = 1'b1;
  endtask

  task automatic run_inc(input int n);
    @(posedge clk);
    #2 pc_inc = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with pc_inc low, pulsed between edges
    #2 n_reset = 1'b0;
    #1;
    check("init_rst_a", pc_a, 0);
    check("init_rst_b", pc_b, 0);
    check("init_rst_c", pc_c, 16);
    n_reset = 1'b1;
    check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("hold_after_rst", pc_a, 0);

    // Counting 30 steps, then hold
    run_inc(30);
    check("count30_a", pc_a, 30);
    check("count30_c", pc_c, 46);
    #1 pc_inc = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("hold30", pc_a, 30);

    // Mid-run reset at 17, held across an edge with pc_inc high
    pulse_reset();
    run_inc(17);
    check("mid_17", pc_a, 17);
    #1 n_reset = 1'b0;
    #1;
    check("mid_rst_a", pc_a, 0);
    check("mid_rst_c", pc_c, 16);
    @(posedge clk);
    #1 check("rst_beats_inc", pc_a, 0);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_a", pc_a, 1);
    check("first_edge_c", pc_c, 17);
    #1 pc_inc = 1'b0;

    // Wrap vs saturate at the top address
    pulse_reset();
    run_inc(255);
    check("top_a", pc_a, 255);
    check("top_b", pc_b, 255);
    check("top_c", pc_c, 15);
    @(posedge clk);
    #1;
    check("wrap_a", pc_a, 0);
    check("sat_b", pc_b, 255);
    check("wrap_c", pc_c, 16);
    #1 pc_inc = 1'b0;

    // Randomised increments with occasional asynchronous reset pulses
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2 pc_inc = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 149) == 0) begin
        n_reset = 1'b0;
        #1;
        check("rand_rst_a", pc_a, m_a);
        check("rand_rst_c", pc_c, m_c);
        n_reset = 1'b1;
      end
    end
    @(posedge clk);
    #2 pc_inc = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
